wall_collision_judge: RTL

//  Consumer of the annotated pixel stream from the game logic controller (hcount/vcount,

---
 rtl/game_pkg.sv | 17 +
 rtl/collision_frame_counter.sv | 43 ++++
 rtl/wall_collision_judge.sv | 112 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the wall collision judge.
// The COLLISION_OVERLAY_EN build option is handled in wall_collision_judge.
package game_pkg;
    typedef enum logic [0:0] {
        S_PLAY      = 1'b0,
        S_GAME_OVER = 1'b1
    } judge_state_t;

    localparam logic [15:0] OVERLAY_RGB565 = 16'hF800;
    localparam int LIVES_WIDTH = 4;
    localparam int SCORE_WIDTH = 8;

    // Widened to 9 bits and subtracted in the non-negative direction, so it never wraps.
    function automatic logic [8:0] depth_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction
endpackage

// File: rtl/collision_frame_counter.sv
// Saturating per-frame collision accumulator.
// Latches the frame total and the hit flag when the last pixel of the frame arrives.
module collision_frame_counter #(
    parameter int SCREEN_WIDTH        = 1280,
    parameter int SCREEN_HEIGHT       = 720,
    parameter int HIT_PIXEL_THRESHOLD = 64,
    parameter int COUNT_WIDTH         = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   data_valid_in,
    input  logic                   collision_in,
    output logic [COUNT_WIDTH-1:0] frame_count_out,
    output logic                   frame_hit_out,
    output logic                   end_hit_out
);
    logic [COUNT_WIDTH-1:0] acc;
    logic [COUNT_WIDTH-1:0] total;
    logic                   frame_end;

    // The final pixel of the frame is folded in before the total is latched.
    assign total = (collision_in && acc != '1) ? acc + 1'b1 : acc;
    assign frame_end = data_valid_in && (hcount_in == 11'(SCREEN_WIDTH - 1))
                       && (vcount_in == 10'(SCREEN_HEIGHT - 1));
    assign end_hit_out = frame_end && (total >= COUNT_WIDTH'(HIT_PIXEL_THRESHOLD));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc             <= '0;
            frame_count_out <= '0;
            frame_hit_out   <= 1'b0;
        end else if (frame_end) begin
            acc             <= '0;
            frame_count_out <= total;
            frame_hit_out   <= end_hit_out;
        end else begin
            acc             <= total;
            frame_hit_out   <= 1'b0;
        end
    end
endmodule

// File: rtl/wall_collision_judge.sv
// Round/score/lives judge over the annotated pixel stream.
// Define COLLISION_OVERLAY_EN to add a 1-cycle delayed pixel overlay path.
module wall_collision_judge
    import game_pkg::*;
#(
    parameter int SCREEN_WIDTH        = 1280,
    parameter int SCREEN_HEIGHT       = 720,
    parameter int DEPTH_TOLERANCE     = 10,
    parameter int HIT_PIXEL_THRESHOLD = 64,
    parameter int START_LIVES         = 3,
    parameter int COUNT_WIDTH         = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   data_valid_in,
    input  logic                   is_wall_in,
    input  logic                   is_person_in,
    input  logic [7:0]             wall_depth_in,
    input  logic [7:0]             player_depth_in,
    input  logic                   round_end_in,
`ifdef COLLISION_OVERLAY_EN
    input  logic [15:0]            pixel_in,
    output logic [15:0]            pixel_out,
    output logic [10:0]            hcount_out,
    output logic [9:0]             vcount_out,
    output logic                   data_valid_out,
`endif
    output logic [COUNT_WIDTH-1:0] frame_count_out,
    output logic                   frame_hit_out,
    output logic                   round_valid_out,
    output logic                   round_pass_out,
    output logic [SCORE_WIDTH-1:0] score_out,
    output logic [LIVES_WIDTH-1:0] lives_out,
    output logic                   game_over_out
);
    judge_state_t state;
    logic         collision;
    logic         end_hit;
    logic         round_hit;
    logic         pass;

    assign collision = data_valid_in && is_wall_in && is_person_in
                       && (depth_diff(wall_depth_in, player_depth_in) <= 9'(DEPTH_TOLERANCE));

    collision_frame_counter #(
        .SCREEN_WIDTH       (SCREEN_WIDTH),
        .SCREEN_HEIGHT      (SCREEN_HEIGHT),
        .HIT_PIXEL_THRESHOLD(HIT_PIXEL_THRESHOLD),
        .COUNT_WIDTH        (COUNT_WIDTH)
    ) u_counter (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .data_valid_in  (data_valid_in),
        .collision_in   (collision),
        .frame_count_out(frame_count_out),
        .frame_hit_out  (frame_hit_out),
        .end_hit_out    (end_hit)
    );

    // A frame ending on the round_end cycle still counts against the ending round.
    assign pass = !(round_hit || end_hit);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= S_PLAY;
            round_hit       <= 1'b0;
            round_valid_out <= 1'b0;
            round_pass_out  <= 1'b0;
            score_out       <= '0;
            lives_out       <= LIVES_WIDTH'(START_LIVES);
            game_over_out   <= 1'b0;
        end else begin
            round_valid_out <= 1'b0;
            if (state == S_PLAY && round_end_in) begin
                round_valid_out <= 1'b1;
                round_pass_out  <= pass;
                round_hit       <= 1'b0;
                if (pass) begin
                    if (score_out != '1) score_out <= score_out + 1'b1;
                end else begin
                    lives_out <= lives_out - 1'b1;
                    if (lives_out == LIVES_WIDTH'(1)) begin
                        state         <= S_GAME_OVER;
                        game_over_out <= 1'b1;
                    end
                end
            end else if (end_hit) begin
                round_hit <= 1'b1;
            end
        end
    end

`ifdef COLLISION_OVERLAY_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pixel_out      <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            data_valid_out <= 1'b0;
        end else begin
            pixel_out      <= collision ? OVERLAY_RGB565 : pixel_in;
            hcount_out     <= hcount_in;
            vcount_out     <= vcount_in;
            data_valid_out <= data_valid_in;
        end
    end
`endif
endmodule
